button_conditioner: RTL and testbench

- Front-end stage for the five-button clock/alarm controller: 2-FF synchronizer, per-button debounce, rising-edge one-shot, auto-repeat for up/down, one-hot arbitration.
- Drives the controller's button-event vector directly. Guarantees at most one bit high per cycle, so the controller's one-hot compares always match a legal code.
- Runs on the system clock. Debounce and repeat timing advance only on an external sample-enable tick.

---
 rtl/button_conditioner.sv | 119 +++++++++++
 tb/tb_button_conditioner.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Five-button front end: synchronize, debounce, one-shot, auto-repeat,
// and one-hot arbitration onto a registered event vector.
module button_conditioner #(
  parameter int         DEB_TICKS    = 4,
  parameter int         HOLD_TICKS   = 200,
  parameter int         REPEAT_TICKS = 50,
  parameter logic [4:0] REPEAT_MASK  = 5'b01100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [4:0] btn_in,
  output logic [4:0] btn_level,
  output logic [4:0] btn_pulse
);

  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ?
                        HOLD_TICKS : REPEAT_TICKS;
  localparam int HW = $clog2(HMAX + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] REP_LAST = HW'(REPEAT_TICKS - 1);

  logic [4:0]    sync_a;
  logic [4:0]    sync_b;
  logic [4:0]    level_d;
  logic [DW-1:0] deb_cnt [5];
  logic [HW-1:0] hold_cnt [5];
  logic [4:0]    rep_ph;
  logic [4:0]    rep_evt;
  logic [4:0]    events;
  logic [4:0]    pick;

  // Two-flop synchronizer, free-running every clock
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn_in;
      sync_b <= sync_a;
    end
  end

  // Debounce: level flips after DEB_TICKS consecutive differing ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level <= '0;
      for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < 5; i++) begin
        if (sync_b[i] != btn_level[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            btn_level[i] <= ~btn_level[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Delayed level for rising-edge press detection
  always_ff @(posedge clk) begin
    if (rst) level_d <= '0;
    else level_d <= btn_level;
  end

  // Hold/repeat timers; rep_evt is a one-cycle flag per repeat
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_ph <= '0;
      rep_evt <= '0;
      for (int i = 0; i < 5; i++) hold_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        rep_evt[i] <= 1'b0;
        if (!btn_level[i] || !REPEAT_MASK[i]) begin
          hold_cnt[i] <= '0;
          rep_ph[i] <= 1'b0;
        end else if (en) begin
          if (hold_cnt[i] == (rep_ph[i] ? REP_LAST : HOLD_LAST)) begin
            hold_cnt[i] <= '0;
            rep_ph[i] <= 1'b1;
            rep_evt[i] <= 1'b1;
          end else begin
            hold_cnt[i] <= hold_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // Highest-index event wins; the rest are dropped
  always_comb begin
    events = (btn_level & ~level_d) | rep_evt;
    pick = '0;
    priority case (1'b1)
      events[4]: pick = 5'b10000;
      events[3]: pick = 5'b01000;
      events[2]: pick = 5'b00100;
      events[1]: pick = 5'b00010;
      events[0]: pick = 5'b00001;
      default:   pick = '0;
    endcase
  end

  // Registered one-hot event output
  always_ff @(posedge clk) begin
    if (rst) btn_pulse <= '0;
    else btn_pulse <= pick;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: vector table, corner sequences,
// and random stimulus against a tick-schedule reference model.
module tb_button_conditioner;

  localparam int DEB = 4;
  localparam int HOLD = 10;
  localparam int REP = 3;
  localparam logic [4:0] MASK = 5'b01100;

  logic       clk;
  logic       rst;
  logic       en;
  logic [4:0] btn_in;
  logic [4:0] btn_level;
  logic [4:0] btn_pulse;

  button_conditioner #(
    .DEB_TICKS(DEB),
    .HOLD_TICKS(HOLD),
    .REPEAT_TICKS(REP),
    .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ec = 0;
  int p_edge[$];
  logic [4:0] p_val[$];

  // reference model state
  bit [4:0] m_s1, m_s2, m_lvl, m_prev, m_rep, m_pls;
  int m_dc[5];
  int m_held[5];
  int m_next[5];

  task automatic chk(input string nm, input logic [4:0] act,
                     input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%b want=%b", nm, ec, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic void m_clear();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prev = '0;
    m_rep = '0; m_pls = '0;
    for (int i = 0; i < 5; i++) begin
      m_dc[i] = 0; m_held[i] = 0; m_next[i] = HOLD;
    end
  endfunction

  // Repeats are due at cumulative held ticks HOLD, HOLD+REP, ...
  function automatic void m_step(input bit r, input bit e,
                                 input bit [4:0] b);
    bit [4:0] ev;
    bit [4:0] np;
    bit [4:0] nr;
    bit found;
    ev = (m_lvl & ~m_prev) | m_rep;
    np = '0;
    found = 0;
    for (int i = 4; i >= 0; i--)
      if (ev[i] && !found) begin np[i] = 1; found = 1; end
    if (r) begin
      m_clear();
      return;
    end
    m_pls = np;
    m_prev = m_lvl;
    nr = '0;
    for (int i = 0; i < 5; i++) begin
      if (!m_lvl[i] || !MASK[i]) begin
        m_held[i] = 0; m_next[i] = HOLD;
      end else if (e) begin
        m_held[i]++;
        if (m_held[i] == m_next[i]) begin
          nr[i] = 1; m_next[i] += REP;
        end
      end
    end
    m_rep = nr;
    if (e)
      for (int i = 0; i < 5; i++) begin
        if (m_s2[i] != m_lvl[i]) begin
          m_dc[i]++;
          if (m_dc[i] == DEB) begin
            m_lvl[i] = ~m_lvl[i]; m_dc[i] = 0;
          end
        end else m_dc[i] = 0;
      end
    m_s2 = m_s1;
    m_s1 = b;
  endfunction

  task automatic tick(input logic r, input logic e, input logic [4:0] b);
    rst = r; en = e; btn_in = b;
    @(posedge clk);
    m_step(r, e, b);
    #1;
    ec++;
    chk("model_level", btn_level, m_lvl);
    chk("model_pulse", btn_pulse, m_pls);
    total++;
    if ($countones(btn_pulse) > 1) begin
      bad++;
      $display("FAIL onehot edge=%0d got=%b want=<=1 bit", ec, btn_pulse);
    end
    if (btn_pulse != 0) begin
      p_edge.push_back(ec);
      p_val.push_back(btn_pulse);
    end
  endtask

  task automatic restart(input logic [4:0] b);
    tick(1, 1, b);
    tick(1, 1, b);
    p_edge.delete();
    p_val.delete();
    ec = 0;
  endtask

  task automatic run(input int n, input logic [4:0] b);
    for (int i = 0; i < n; i++) tick(0, 1, b);
  endtask

  typedef struct {
    logic       r;
    logic       e;
    logic [4:0] b;
    logic [4:0] lvl;
    logic [4:0] pls;
  } vec_t;

  vec_t tv[$];

  initial begin
    int k;
    int ne;
    m_clear();
    rst = 1; en = 1; btn_in = '0;

    // reset with all buttons held, then release reset
    for (int i = 0; i < 3; i++)
      tv.push_back('{1, 1, 5'h1f, 5'h00, 5'h00});
    for (int i = 1; i <= 5; i++)
      tv.push_back('{0, 1, 5'h1f, 5'h00, 5'h00});
    tv.push_back('{0, 1, 5'h1f, 5'h1f, 5'h00});
    tv.push_back('{0, 1, 5'h1f, 5'h1f, 5'h10});
    for (int i = 8; i <= 10; i++)
      tv.push_back('{0, 1, 5'h1f, 5'h1f, 5'h00});
    tv.push_back('{1, 1, 5'h00, 5'h00, 5'h00});
    // 3-cycle glitch on bit1 never reaches the level
    for (int i = 0; i < 3; i++)
      tv.push_back('{0, 1, 5'h02, 5'h00, 5'h00});
    for (int i = 0; i < 8; i++)
      tv.push_back('{0, 1, 5'h00, 5'h00, 5'h00});

    foreach (tv[j]) begin
      tick(tv[j].r, tv[j].e, tv[j].b);
      chk("tbl_level", btn_level, tv[j].lvl);
      chk("tbl_pulse", btn_pulse, tv[j].pls);
    end

    // bit1 held: one press pulse at edge 7, none on release
    restart(5'h00);
    run(20, 5'h02);
    run(12, 5'h00);
    chk_int("deb_npulse", p_edge.size(), 1);
    if (p_edge.size() > 0) begin
      chk_int("deb_edge", p_edge[0], 7);
      chk("deb_val", p_val[0], 5'b00010);
    end

    // up auto-repeat: 7, 17, then every 3
    restart(5'h00);
    run(40, 5'h04);
    ne = 0;
    for (int e = 7; e <= 40; e += (e == 7) ? 10 : 3) ne++;
    k = 0;
    foreach (p_edge[j]) if (p_edge[j] <= 40) k++;
    chk_int("rep_count", k, ne);
    if (p_edge.size() >= 3) begin
      chk_int("rep_e0", p_edge[0], 7);
      chk_int("rep_e1", p_edge[1], 17);
      chk_int("rep_e2", p_edge[2], 20);
      chk("rep_val", p_val[2], 5'b00100);
    end
    run(20, 5'h00);

    // left has no repeat
    restart(5'h00);
    run(40, 5'h01);
    chk_int("norep_count", p_edge.size(), 1);

    // centre beats down; down still repeats on schedule
    restart(5'h00);
    run(21, 5'h18);
    if (p_edge.size() >= 2) begin
      chk_int("sim_e0", p_edge[0], 7);
      chk("sim_v0", p_val[0], 5'b10000);
      chk_int("sim_e1", p_edge[1], 17);
      chk("sim_v1", p_val[1], 5'b01000);
    end else chk_int("sim_count", p_edge.size(), 3);

    // reset during down repeat with button held
    restart(5'h00);
    run(25, 5'h08);
    restart(5'h08);
    run(20, 5'h08);
    if (p_edge.size() >= 2) begin
      chk_int("mrst_e0", p_edge[0], 7);
      chk_int("mrst_e1", p_edge[1], 17);
      chk("mrst_v1", p_val[1], 5'b01000);
    end else chk_int("mrst_count", p_edge.size(), 2);

    // en every 4th clock: one-clock-wide press pulse
    restart(5'h00);
    for (int i = 0; i < 40; i++) tick(0, (i % 4) == 3, 5'h01);
    chk_int("en_width", p_edge.size(), 1);
    chk("en_level", btn_level, 5'b00001);

    // random soak against the model
    restart(5'h00);
    begin
      logic [4:0] b;
      b = '0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 9) == 0) b[$urandom_range(0, 4)] ^= 1'b1;
        tick($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, b);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
